nand_latch_cycle: RTL and testbench
===================================

// Module: nand_latch_cycle
// PURPOSE
//  Downstream of the command-byte selector. Turns one command or address byte into a
//  timed NAND latch cycle: CE#/CLE/ALE setup, a WE# low pulse, then hold.
//  Pulses done when the cycle completes. Sits between the controller FSM / command
//  selector and the NAND pads; the FSM issues one request per byte.
// PARAMETERS
//  T_SETUP     2      clk cycles CE#/CLE/ALE/IO are valid before WE# falls (0 treated as 1)
//  T_WP        3      clk cycles WE# is held low (0 treated as 1)
//  T_WH        2      clk cycles WE# is high with CLE/ALE/IO held after the rising edge (0 treated as 1)
//  T_WB        4      max clk cycles to wait for R/B# to fall (WAIT_RB_EN only)
//  RB_TIMEOUT  1000   max clk cycles to wait for R/B# to rise (WAIT_RB_EN only)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous, active-high reset
//  req          in   1  start a latch cycle; sampled only while busy=0
//  req_is_addr  in   1  0: command cycle (CLE), 1: address cycle (ALE)
//  req_wait_rb  in   1  after the cycle, wait for R/B# busy/ready (WAIT_RB_EN only)
//  req_byte     in   8  byte to drive (cmd_data from the command selector)
//  busy         out  1  cycle in progress
//  done         out  1  one-cycle pulse at completion
//  timeout      out  1  one-cycle pulse with done when the R/B# rise wait expires
//  nand_ce_n    out  1  chip enable, active low
//  nand_cle     out  1  command latch enable
//  nand_ale     out  1  address latch enable
//  nand_we_n    out  1  write enable, active low
//  nand_io_out  out  8  IO bus output data
//  nand_io_oe   out  1  IO bus output enable
//  nand_rb_n    in   1  ready/busy#, asynchronous pad input
// BEHAVIOUR
//  - All outputs are registered. Reset values:
//    ce_n=1, cle=0, ale=0, we_n=1, io_out=0, io_oe=0, busy=0, done=0, timeout=0; state IDLE.
//  - Reset is synchronous and overrides everything. Reset mid-cycle returns outputs to
//    reset values at the next edge, with WE# high; no done pulse is produced.
//  - FSM: IDLE -> SETUP -> WE_LOW -> WE_HIGH -> [RB_FALL -> RB_RISE] -> IDLE.
//  - IDLE: when req=1, latch req_is_addr, req_wait_rb and req_byte, then enter SETUP.
//    A req arriving while busy=1 is ignored; it is not queued.
//  - SETUP (T_SETUP cycles): ce_n=0, io_oe=1, io_out=byte, we_n=1.
//    cle=~is_addr and ale=is_addr; the two are never both high.
//  - WE_LOW (T_WP cycles): we_n=0; all other outputs held.
//  - WE_HIGH (T_WH cycles): we_n=1; CLE/ALE/IO held.
//    On exit: cle=0, ale=0, io_oe=0, ce_n=1, done=1 for one cycle, busy=0.
//  - Timing: req sampled at edge 0 -> busy=1 from edge 1 -> done=1 at edge
//    1+T_SETUP+T_WP+T_WH (edge 8 with defaults).
//  - A new req may be accepted in the cycle done is high (back-to-back); CE# then
//    deasserts for exactly one cycle between bytes.
//  - Phase counters are 16-bit, count down, and reload on each state entry.
// CONFIGURATION
//  WAIT_RB_EN defined:
//   - nand_rb_n passes through a 2-flop synchronizer.
//   - If the latched wait_rb=1, WE_HIGH exits to RB_FALL instead of completing.
//     ce_n stays 0; cle, ale and io_oe are 0.
//   - RB_FALL: wait until synced rb_n=0, or until T_WB cycles elapse (then proceed anyway).
//     Then enter RB_RISE.
//   - RB_RISE: when synced rb_n=1, complete as above.
//     After RB_TIMEOUT cycles with rb_n still 0, complete with timeout=1 and done=1
//     in the same cycle.
//  WAIT_RB_EN undefined:
//   - RB states and synchronizer are absent; req_wait_rb and nand_rb_n are ignored.
//   - timeout is tied to 0.
// TESTING
//  1. Reset, then req=1, req_is_addr=0, req_byte=8'h80 at edge 0 ->
//     cle=1, ce_n=0, io_out=80, io_oe=1 over edges 1-7; we_n=0 exactly over edges 3-5;
//     done=1 at edge 8 only; ale never 1.
//  2. Addr 8'h12 then addr 8'h34 back-to-back (second req in the done cycle) ->
//     two WE# pulses, ale=1 on both, cle=0, io_out 12 then 34.
//  3. Extra req pulses while busy=1 -> ignored: exactly one WE# pulse, one done.
//  4. rst=1 at edge 4 (inside WE_LOW) -> at edge 5 we_n=1, ce_n=1, busy=0; no done pulse.
//  5. WAIT_RB_EN: cmd 8'h10, wait_rb=1; rb_n falls 2 cycles after WE_HIGH and rises 50 later ->
//     done one cycle after the synced rise (synchronizer latency included); timeout=0.
//  6. WAIT_RB_EN: rb_n held low -> done=1 and timeout=1 together after RB_TIMEOUT cycles in RB_RISE.
//     Without the macro: same stimulus -> done at edge 8, timeout=0.

Source files
------------

// File: rtl/nand_latch_cycle.sv
// NAND command/address latch-cycle generator: CE#/CLE/ALE setup, WE# low pulse, hold, done pulse.
// Define WAIT_RB_EN to add the post-cycle R/B# fall/rise wait with a 2-flop pad synchronizer.

module nand_latch_cycle #(
  parameter int unsigned T_SETUP    = 2,
  parameter int unsigned T_WP       = 3,
  parameter int unsigned T_WH       = 2,
  parameter int unsigned T_WB       = 4,
  parameter int unsigned RB_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       req_is_addr,
  input  logic       req_wait_rb,
  input  logic [7:0] req_byte,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic       nand_ce_n,
  output logic       nand_cle,
  output logic       nand_ale,
  output logic       nand_we_n,
  output logic [7:0] nand_io_out,
  output logic       nand_io_oe,
  input  logic       nand_rb_n
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BYTE_W = 8;

  // Zero-length phases are stretched to one cycle.
  localparam int unsigned T_SETUP_E = (T_SETUP == 0)    ? 1 : T_SETUP;
  localparam int unsigned T_WP_E    = (T_WP == 0)       ? 1 : T_WP;
  localparam int unsigned T_WH_E    = (T_WH == 0)       ? 1 : T_WH;
  localparam int unsigned T_WB_E    = (T_WB == 0)       ? 1 : T_WB;
  localparam int unsigned T_TO_E    = (RB_TIMEOUT == 0) ? 1 : RB_TIMEOUT;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP_E - 1);
  localparam logic [CNT_W-1:0] WP_LD    = CNT_W'(T_WP_E - 1);
  localparam logic [CNT_W-1:0] WH_LD    = CNT_W'(T_WH_E - 1);
  localparam logic [CNT_W-1:0] WB_LD    = CNT_W'(T_WB_E - 1);
  localparam logic [CNT_W-1:0] TO_LD    = CNT_W'(T_TO_E - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WE_LOW,
    S_WE_HIGH,
    S_RB_FALL,
    S_RB_RISE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic                is_addr_q, is_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic                ce_n_q, ce_n_d;
  logic                cle_q, cle_d;
  logic                ale_q, ale_d;
  logic                we_n_q, we_n_d;
  logic [BYTE_W-1:0]   io_out_q, io_out_d;
  logic                io_oe_q, io_oe_d;

`ifdef WAIT_RB_EN
  logic wait_rb_q, wait_rb_d;
  logic rb_meta_q, rb_meta_d;
  logic rb_sync_q, rb_sync_d;
`else
  logic unused_rb;
  assign unused_rb = ^{req_wait_rb, nand_rb_n, WB_LD, TO_LD};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      byte_q    <= '0;
      is_addr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      ce_n_q    <= 1'b1;
      cle_q     <= 1'b0;
      ale_q     <= 1'b0;
      we_n_q    <= 1'b1;
      io_out_q  <= '0;
      io_oe_q   <= 1'b0;
`ifdef WAIT_RB_EN
      wait_rb_q <= 1'b0;
      rb_meta_q <= 1'b1;
      rb_sync_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      byte_q    <= byte_d;
      is_addr_q <= is_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      ce_n_q    <= ce_n_d;
      cle_q     <= cle_d;
      ale_q     <= ale_d;
      we_n_q    <= we_n_d;
      io_out_q  <= io_out_d;
      io_oe_q   <= io_oe_d;
`ifdef WAIT_RB_EN
      wait_rb_q <= wait_rb_d;
      rb_meta_q <= rb_meta_d;
      rb_sync_q <= rb_sync_d;
`endif
    end
  end

  // Next state, phase countdown, and pad values registered from the next state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    is_addr_d = is_addr_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
`ifdef WAIT_RB_EN
    wait_rb_d = wait_rb_q;
    rb_meta_d = nand_rb_n;
    rb_sync_d = rb_meta_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d   = S_SETUP;
          cnt_d     = SETUP_LD;
          byte_d    = req_byte;
          is_addr_d = req_is_addr;
`ifdef WAIT_RB_EN
          wait_rb_d = req_wait_rb;
`endif
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_WE_LOW;
          cnt_d   = WP_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WE_LOW: begin
        if (cnt_q == '0) begin
          state_d = S_WE_HIGH;
          cnt_d   = WH_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WE_HIGH: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
`ifdef WAIT_RB_EN
          if (wait_rb_q) begin
            state_d = S_RB_FALL;
            cnt_d   = WB_LD;
            done_d  = 1'b0;
          end
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef WAIT_RB_EN
      // Device may never show busy; give up on the fall after T_WB cycles.
      S_RB_FALL: begin
        if (!rb_sync_q || cnt_q == '0) begin
          state_d = S_RB_RISE;
          cnt_d   = TO_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RB_RISE: begin
        if (rb_sync_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d != S_IDLE);
    ce_n_d   = 1'b1;
    cle_d    = 1'b0;
    ale_d    = 1'b0;
    we_n_d   = 1'b1;
    io_oe_d  = 1'b0;
    io_out_d = '0;
    case (state_d)
      S_SETUP, S_WE_LOW, S_WE_HIGH: begin
        ce_n_d   = 1'b0;
        cle_d    = ~is_addr_d;
        ale_d    = is_addr_d;
        io_oe_d  = 1'b1;
        io_out_d = byte_d;
        we_n_d   = (state_d != S_WE_LOW);
      end
      S_RB_FALL, S_RB_RISE: ce_n_d = 1'b0;
      default: ;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign nand_ce_n   = ce_n_q;
  assign nand_cle    = cle_q;
  assign nand_ale    = ale_q;
  assign nand_we_n   = we_n_q;
  assign nand_io_out = io_out_q;
  assign nand_io_oe  = io_oe_q;

endmodule

// File: tb/tb_nand_latch_cycle.sv
// Bench for nand_latch_cycle: vector table, hand-written reset/R/B# sequences, and random
// traffic checked against a per-request timeline model. Honours WAIT_RB_EN when defined.

module tb_nand_latch_cycle;

  localparam int T_SETUP    = 2;
  localparam int T_WP       = 3;
  localparam int T_WH       = 2;
  localparam int T_WB       = 4;
  localparam int RB_TIMEOUT = 1000;
  localparam int SPH        = T_SETUP + T_WP + T_WH;
`ifdef WAIT_RB_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       req_is_addr = 1'b0;
  logic       req_wait_rb = 1'b0;
  logic [7:0] req_byte = 8'h00;
  logic       nand_rb_n = 1'b1;
  logic       busy, done, timeout, nand_ce_n, nand_cle, nand_ale, nand_we_n, nand_io_oe;
  logic [7:0] nand_io_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nand_latch_cycle dut (
    .clk(clk), .rst(rst), .req(req), .req_is_addr(req_is_addr), .req_wait_rb(req_wait_rb),
    .req_byte(req_byte), .busy(busy), .done(done), .timeout(timeout), .nand_ce_n(nand_ce_n),
    .nand_cle(nand_cle), .nand_ale(nand_ale), .nand_we_n(nand_we_n),
    .nand_io_out(nand_io_out), .nand_io_oe(nand_io_oe), .nand_rb_n(nand_rb_n)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       timeout;
    logic       ce_n;
    logic       cle;
    logic       ale;
    logic       we_n;
    logic       io_oe;
    logic [7:0] io;
  } obs_t;

  typedef struct {
    bit         rst;
    bit         req;
    bit         addr;
    logic [7:0] b;
    obs_t       exp;
  } vec_t;

  vec_t tbl[$];

  function automatic obs_t o_idle();
    obs_t o;
    o = '0;
    o.ce_n = 1'b1;
    o.we_n = 1'b1;
    return o;
  endfunction

  function automatic obs_t o_done(bit to);
    obs_t o;
    o = o_idle();
    o.done = 1'b1;
    o.timeout = to;
    return o;
  endfunction

  function automatic obs_t o_drv(bit a, logic [7:0] b, bit we_n);
    obs_t o;
    o = '0;
    o.busy = 1'b1;
    o.cle = !a;
    o.ale = a;
    o.we_n = we_n;
    o.io_oe = 1'b1;
    o.io = b;
    return o;
  endfunction

  function automatic obs_t o_rb();
    obs_t o;
    o = '0;
    o.busy = 1'b1;
    o.we_n = 1'b1;
    return o;
  endfunction

  function automatic obs_t sample_dut();
    obs_t o;
    o.busy = busy;   o.done = done;     o.timeout = timeout; o.ce_n = nand_ce_n;
    o.cle = nand_cle; o.ale = nand_ale; o.we_n = nand_we_n;  o.io_oe = nand_io_oe;
    o.io = nand_io_out;
    return o;
  endfunction

  // Reference timeline: j = edges since the request was accepted, d = offset of the done edge.
  function automatic obs_t model_obs(int j, int d, bit a, logic [7:0] b);
    if (j < 0) return o_idle();
    if (j == d) return o_done(1'b0);
    if (j < T_SETUP) return o_drv(a, b, 1'b1);
    if (j < T_SETUP + T_WP) return o_drv(a, b, 1'b0);
    if (j < SPH) return o_drv(a, b, 1'b1);
    return o_rb();
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t g;
    g = sample_dut();
    n_cmp++;
    if (g !== exp) begin
      n_bad++;
      $display("FAIL %s: got busy=%0b done=%0b to=%0b ce_n=%0b cle=%0b ale=%0b we_n=%0b oe=%0b io=%02h, expected busy=%0b done=%0b to=%0b ce_n=%0b cle=%0b ale=%0b we_n=%0b oe=%0b io=%02h",
               name, g.busy, g.done, g.timeout, g.ce_n, g.cle, g.ale, g.we_n, g.io_oe, g.io,
               exp.busy, exp.done, exp.timeout, exp.ce_n, exp.cle, exp.ale, exp.we_n, exp.io_oe, exp.io);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are looked at 1 time unit after the rising edge.
  task automatic step(input bit r, input bit q, input bit a, input bit w, input logic [7:0] b);
    @(negedge clk);
    rst = r; req = q; req_is_addr = a; req_wait_rb = w; req_byte = b;
    @(posedge clk);
    #1;
  endtask

  task automatic add_row(input bit r, input bit q, input bit a, input logic [7:0] b, input obs_t e);
    vec_t v;
    v.rst = r; v.req = q; v.addr = a; v.b = b; v.exp = e;
    tbl.push_back(v);
  endtask

  // One full latch cycle; qpat injects extra (conflicting) requests while busy.
  task automatic add_cycle(input bit a, input logic [7:0] b, input logic [6:0] qpat);
    obs_t e;
    add_row(1'b0, 1'b1, a, b, o_drv(a, b, 1'b1));
    for (int k = 0; k < 7; k++) begin
      if (k < 1)      e = o_drv(a, b, 1'b1);
      else if (k < 4) e = o_drv(a, b, 1'b0);
      else if (k < 6) e = o_drv(a, b, 1'b1);
      else            e = o_done(1'b0);
      add_row(1'b0, qpat[k], !a, ~b, e);
    end
  endtask

  initial begin
    int         jd;
    int         tflag;
    int         mj;
    int         md;
    bit         ma;
    logic [7:0] mb;
    bit         r, q, a, w;
    logic [7:0] b;

    // Reset, single command 80h, ignored requests while busy, back-to-back addresses 12h/34h.
    add_row(1'b1, 1'b0, 1'b0, 8'h00, o_idle());
    add_cycle(1'b0, 8'h80, 7'b0000000);
    add_row(1'b0, 1'b0, 1'b0, 8'h00, o_idle());
    add_cycle(1'b1, 8'hA5, 7'b1011011);
    add_row(1'b0, 1'b0, 1'b0, 8'h00, o_idle());
    add_cycle(1'b1, 8'h12, 7'b0000000);
    add_cycle(1'b1, 8'h34, 7'b0000000);
    add_row(1'b0, 1'b0, 1'b0, 8'h00, o_idle());

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].addr, 1'b0, tbl[i].b);
      check($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // Reset while WE# is low: pads return to idle, no done pulse follows.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h90);
    check("rst_mid_setup", o_drv(1'b0, 8'h90, 1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("rst_mid_we_low", o_drv(1'b0, 8'h90, 1'b0));
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("rst_mid_applied", o_idle());
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check($sformatf("rst_mid_after%0d", k), o_idle());
    end

`ifdef WAIT_RB_EN
    // R/B# falls after the WE# pulse and rises 50 cycles later.
    nand_rb_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h10);
    check("rb_cycle_setup", o_drv(1'b0, 8'h10, 1'b1));
    jd = -1;
    tflag = -1;
    for (int j = 1; j <= 200 && jd < 0; j++) begin
      if (j == 7) nand_rb_n = 1'b0;
      if (j == 57) nand_rb_n = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      if (j == 30) check("rb_wait_pads", o_rb());
      if (done === 1'b1) begin
        jd = j;
        tflag = (timeout === 1'b1) ? 1 : 0;
      end
    end
    check_int("rb_rise_done_edge", jd, 57 + 2);
    check_int("rb_rise_timeout", tflag, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("rb_rise_idle", o_idle());
`endif

    // R/B# stuck low with wait requested.
    nand_rb_n = 1'b0;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h70);
    jd = -1;
    tflag = -1;
    for (int j = 1; j <= 1100 && jd < 0; j++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      if (j == SPH - 1) check("stuck_rb_we_high", o_drv(1'b0, 8'h70, 1'b1));
      if (done === 1'b1) begin
        jd = j;
        tflag = (timeout === 1'b1) ? 1 : 0;
      end
    end
    check_int("stuck_rb_done_edge", jd, RB_EN ? SPH + 1 + RB_TIMEOUT : SPH);
    check_int("stuck_rb_timeout", tflag, RB_EN ? 1 : 0);
    nand_rb_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("stuck_rb_idle", o_idle());

    // Random traffic with R/B# held ready.
    mj = -1;
    md = SPH;
    ma = 1'b0;
    mb = 8'h00;
    for (int c = 0; c < 600; c++) begin
      r = ($urandom_range(49) == 0);
      q = ($urandom_range(2) == 0);
      a = 1'($urandom_range(1));
      w = 1'($urandom_range(1));
      b = 8'($urandom);
      step(r, q, a, w, b);
      if (r) mj = -1;
      else if (mj >= 0 && mj < md) mj++;
      else if (q) begin
        mj = 0;
        ma = a;
        mb = b;
        md = SPH + ((w && RB_EN) ? T_WB + 1 : 0);
      end else mj = -1;
      check($sformatf("rnd%0d", c), model_obs(mj, md, ma, mb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
